// File: rtl/alu_wide_sequencer.sv
// Drives a 16-bit combinational ALU in two chained passes (low, then high) to execute 32-bit ops.
// Optional feature macro ALU_SEQ_ILLEGAL_CHK_EN: adds rsp_err and short-circuits illegal opcodes.
`timescale 1ns/1ps

module alu_wide_sequencer #(
  parameter int ALU_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic              rsp_v,
  output logic              rsp_zero,
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  output logic              rsp_err,
`endif
  output logic [ALU_W-1:0]  alu_x,
  output logic [ALU_W-1:0]  alu_y,
  output logic              alu_cin,
  output logic [3:0]        alu_opcode,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_cout,
  input  logic              alu_v
);

  generate
    if (DATA_W != 2 * ALU_W) begin : g_width_check
      $error("DATA_W must equal 2*ALU_W");
    end
  endgenerate

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // SUB and SLT run on the ALU's adder as a + ~b + 1.
  function automatic logic f_is_inv(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic f_is_arith(input logic [3:0] op);
    return (op == OP_ADD) || f_is_inv(op);
  endfunction

  function automatic logic [3:0] f_alu_op(input logic [3:0] op);
    return f_is_arith(op) ? OP_ADD : op;
  endfunction

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  function automatic logic f_is_legal(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || f_is_arith(op);
  endfunction
`endif

  state_e             r_state;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_result;
  logic               r_cout;
  logic               r_v;
  logic [3:0]         r_op;
  logic [ALU_W-1:0]   r_a_hi;
  logic [ALU_W-1:0]   r_b_hi;
  logic [ALU_W-1:0]   r_res_lo;
  logic [ALU_W-1:0]   r_alu_x;
  logic [ALU_W-1:0]   r_alu_y;
  logic               r_alu_cin;
  logic [3:0]         r_alu_op;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  logic               r_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, operand latches included, is reset so an aborted op leaves no residue.
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_v         <= 1'b0;
      r_op        <= '0;
      r_a_hi      <= '0;
      r_b_hi      <= '0;
      r_res_lo    <= '0;
      r_alu_x     <= '0;
      r_alu_y     <= '0;
      r_alu_cin   <= 1'b0;
      r_alu_op    <= '0;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every branch reads pre-edge register values.
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_a_hi      <= req_a[DATA_W-1:ALU_W];
            r_b_hi      <= req_b[DATA_W-1:ALU_W];
            r_req_ready <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
            if (!f_is_legal(req_op)) begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_result    <= '0;
              r_cout      <= 1'b0;
              r_v         <= 1'b0;
              r_err       <= 1'b1;
            end else begin
`else
            begin
`endif
              // ALU operands are registered, so the low pass is staged here.
              r_state   <= S_LO;
              r_alu_x   <= req_a[ALU_W-1:0];
              r_alu_y   <= f_is_inv(req_op) ? ~req_b[ALU_W-1:0] : req_b[ALU_W-1:0];
              r_alu_cin <= f_is_inv(req_op);
              r_alu_op  <= f_alu_op(req_op);
            end
          end
        end

        S_LO: begin
          r_res_lo  <= alu_out;
          r_alu_x   <= r_a_hi;
          r_alu_y   <= f_is_inv(r_op) ? ~r_b_hi : r_b_hi;
          r_alu_cin <= f_is_arith(r_op) & alu_cout;
          r_state   <= S_HI;
        end

        S_HI: begin
          if (r_op == OP_SLT) begin
            r_result <= {{(DATA_W-1){1'b0}}, alu_out[ALU_W-1] ^ alu_v};
          end else begin
            r_result <= {alu_out, r_res_lo};
          end
          r_cout      <= f_is_arith(r_op) & alu_cout;
          r_v         <= f_is_arith(r_op) & alu_v;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
          r_err       <= 1'b0;
`endif
          r_alu_x     <= '0;
          r_alu_y     <= '0;
          r_alu_cin   <= 1'b0;
          r_alu_op    <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_cout   = r_cout;
  assign rsp_v      = r_v;
  assign rsp_zero   = (r_result == '0);
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  assign rsp_err    = r_err;
`endif
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign alu_cin    = r_alu_cin;
  assign alu_opcode = r_alu_op;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer: behavioural 16-bit ALU plus a 32-bit arithmetic reference.
`timescale 1ns/1ps

module tb_alu_wide_sequencer;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_v, rsp_zero;
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  logic        rsp_err;
`endif
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_cin, alu_cout, alu_v;
  logic [3:0]  alu_opcode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.ALU_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_v(rsp_v), .rsp_zero(rsp_zero),
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    .rsp_err(rsp_err),
`endif
    .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_v(alu_v)
  );

  // Behavioural 16-bit ALU; unknown opcodes return x ^ y so verbatim pass-through is observable.
  always_comb begin
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_opcode)
      OP_AND: alu_out = alu_x & alu_y;
      OP_OR:  alu_out = alu_x | alu_y;
      OP_ADD: begin
        {alu_cout, alu_out} = {1'b0, alu_x} + {1'b0, alu_y} + {16'b0, alu_cin};
        alu_v = (alu_x[15] == alu_y[15]) && (alu_out[15] != alu_x[15]);
      end
      default: alu_out = alu_x ^ alu_y;
    endcase
  end

  function automatic logic is_legal(input logic [3:0] op);
    return op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB || op == OP_SLT;
  endfunction

  // 32-bit reference computed directly, not by splitting into passes.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v,
                                    output logic e, output int lat);
    logic [32:0] s;
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 3;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB, OP_SLT: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        c = s[32];
        v = (a[31] != b[31]) && (s[31] != a[31]);
        r = (op == OP_SUB) ? s[31:0] : (($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
      end
      default: begin
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
        r = '0; e = 1'b1; lat = 1;
`else
        r = a ^ b;
`endif
      end
    endcase
  endfunction

  // One full transaction from an idle negedge back to idle, holding rsp_ready low for 'hold' cycles.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] er;
    logic        ec, ev, ee, inv;
    int          el, lat;
    logic [15:0] ey;
    logic [3:0]  eo;
    ref_model(op, a, b, er, ec, ev, ee, el);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_before: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    inv = (el == 3) && (op == OP_SUB || op == OP_SLT);
    ey  = (el != 3) ? 16'h0 : (inv ? ~b[15:0] : b[15:0]);
    eo  = (el != 3) ? 4'h0 : ((op == OP_ADD || inv) ? OP_ADD : op);
    n_vec++;
    if ({alu_x, alu_y, alu_cin, alu_opcode} !== {((el == 3) ? a[15:0] : 16'h0), ey, inv, eo}) begin
      n_err++;
      $display("FAIL %s lo_pass x/y/cin/op: got %h/%h/%b/%b want %h/%h/%b/%b", tag,
               alu_x, alu_y, alu_cin, alu_opcode, ((el == 3) ? a[15:0] : 16'h0), ey, inv, eo);
    end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== el) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, el);
    end
    n_vec++;
    if ({rsp_result, rsp_cout, rsp_v, rsp_zero} !== {er, ec, ev, (er == 32'd0)}) begin
      n_err++;
      $display("FAIL %s result/cout/v/zero: got %h/%b/%b/%b want %h/%b/%b/%b", tag,
               rsp_result, rsp_cout, rsp_v, rsp_zero, er, ec, ev, (er == 32'd0));
    end
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    n_vec++;
    if (rsp_err !== ee) begin
      n_err++;
      $display("FAIL %s err: got %b want %b", tag, rsp_err, ee);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, er}) begin
        n_err++;
        $display("FAIL %s hold%0d valid/ready/result: got %b/%b/%h want 1/0/%h", tag, i,
                 rsp_valid, req_ready, rsp_result, er);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_vec++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL %s after_handshake valid/ready: got %b/%b want 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({rsp_valid, req_ready, rsp_result, rsp_cout, rsp_v, rsp_zero, alu_x, alu_y, alu_cin, alu_opcode}
        !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b ready=%b res=%h c=%b v=%b z=%b x=%h y=%h cin=%b op=%b want 0 1 0 0 0 1 0 0 0 0",
               rsp_valid, req_ready, rsp_result, rsp_cout, rsp_v, rsp_zero, alu_x, alu_y, alu_cin, alu_opcode);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 32'h0000FFFF, 32'h00000001, 0, "add_carry");
    run_op(OP_SUB, 32'h00000003, 32'h00000008, 0, "sub_neg");
    run_op(OP_SLT, 32'h00000003, 32'h00000008, 0, "slt_true");
    run_op(OP_SUB, 32'h80000000, 32'h00000001, 0, "sub_ovf");
    run_op(OP_AND, 32'h0000000B, 32'h00000009, 0, "and_small");
    run_op(OP_OR,  32'hF0F00000, 32'h0000F0F0, 0, "or_mix");
    run_op(OP_SLT, 32'h7FFFFFFF, 32'h80000000, 0, "slt_ovf");
    run_op(OP_SUB, 32'h12345678, 32'h12345678, 0, "sub_zero");
  endtask

  task automatic test_backpressure();
    run_op(OP_ADD, $urandom, $urandom, 5, "backpressure");
    run_op(OP_SUB, $urandom, $urandom, 0, "after_backpressure");
  endtask

  task automatic test_illegal();
    run_op(4'b1111, 32'hDEAD0000, 32'h0000BEEF, 0, "illegal_1111");
    run_op(4'b0011, $urandom, $urandom, 2, "illegal_0011");
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    req_valid = 1'b1; req_op = OP_ADD; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({alu_x, alu_y} !== {a[31:16], b[31:16]}) begin
      n_err++;
      $display("FAIL mid_hi_operands: got %h/%h want %h/%h", alu_x, alu_y, a[31:16], b[31:16]);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rsp_valid, req_ready, rsp_zero, alu_x, alu_y, alu_cin, alu_opcode} !== {3'b011, 37'h0}) begin
      n_err++;
      $display("FAIL mid_reset valid/ready/zero/x/y/cin/op: got %b/%b/%b/%h/%h/%b/%b want 0/1/1/0/0/0/0",
               rsp_valid, req_ready, rsp_zero, alu_x, alu_y, alu_cin, alu_opcode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL no_stale_rsp%0d valid/ready: got %b/%b want 0/1", i, rsp_valid, req_ready);
      end
    end
    run_op(OP_ADD, a, b, 0, "after_mid_reset");
  endtask

  task automatic test_random();
    logic [31:0] corners [5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00010000};
    logic [3:0]  legal [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 4'($urandom_range(0, 15)); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 4)];
      end
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       begin a = corners[$urandom_range(0, 4)]; b = corners[$urandom_range(0, 4)]; end
        default: b = $urandom;
      endcase
      run_op(op, a, b, $urandom_range(0, 2), $sformatf("rand%0d_op%b", n, op));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
